gravsim_regfile: RTL

Parametrised Avalon-MM register file holding global constants, run control and per-body state (mass, radius, position, velocity, acceleration) for the gravity simulator. It sits between the HPS Avalon-MM bus, the N-body update engine (multi-lane read/write port plus start/done handshake) and the VGA ball renderers. The renderers receive a tear-free shadow copy of radius and position, captured on frame boundaries.

---
 rtl/gravsim_regfile.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/gravsim_regfile.sv
// rtl/gravsim_regfile.sv - gravity simulator register file: host map, run control, engine lanes, display shadow
module gravsim_regfile #(
    parameter int NUM_BODIES = 10,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int LANES      = 6
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         AVL_CS,
    input  logic                         AVL_READ,
    input  logic                         AVL_WRITE,
    input  logic [ADDR_W-1:0]            AVL_ADDR,
    input  logic [DATA_W/8-1:0]          AVL_BYTE_EN,
    input  logic [DATA_W-1:0]            AVL_WRITEDATA,
    output logic [DATA_W-1:0]            AVL_READDATA,
    output logic                         AVL_READDATAVALID,
    output logic                         IRQ,
    output logic                         ENG_START,
    input  logic                         ENG_DONE,
    input  logic                         ENG_CLEAR_ACC,
    input  logic [LANES-1:0]             ENG_RE,
    input  logic [LANES-1:0]             ENG_WE,
    input  logic [LANES*ADDR_W-1:0]      ENG_ADDR,
    input  logic [LANES*DATA_W-1:0]      ENG_WDATA,
    output logic [LANES*DATA_W-1:0]      ENG_RDATA,
    output logic [LANES-1:0]             ENG_RVALID,
    output logic [DATA_W-1:0]            CFG_G,
    output logic [DATA_W-1:0]            CFG_NUM,
    input  logic                         FRAME_SYNC,
    output logic [NUM_BODIES*DATA_W-1:0] DISP_RAD,
    output logic [NUM_BODIES*DATA_W-1:0] DISP_PX,
    output logic [NUM_BODIES*DATA_W-1:0] DISP_PY,
    output logic [NUM_BODIES*DATA_W-1:0] DISP_PZ
);
    localparam int DEPTH      = 8 + 11 * NUM_BODIES;
    localparam int BODY_WORDS = 11 * NUM_BODIES;
    localparam int IDX_W      = $clog2(BODY_WORDS);
    localparam int BE_W       = DATA_W / 8;
    localparam int ACC_LO     = 8 * NUM_BODIES;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] body [BODY_WORDS];
    logic [DATA_W-1:0] reg_g;
    logic [DATA_W-1:0] reg_num;
    logic [DATA_W-1:0] step_count;
    logic              irq_en;
    logic              st_done;
    logic              st_err;
    logic              pending;
    logic              fs_s1, fs_s2, fs_s3;

    logic host_wr, host_rd, wr_ctrl, wr_status, start_req, high_wr;
    logic start_go, done_evt, err_evt, fs_edge;

    function automatic logic body_hit(input logic [ADDR_W-1:0] a);
        return (int'(a) >= 8) && (int'(a) < DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] body_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - ADDR_W'(8));
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
        end
        return r;
    endfunction

    // Shared by the host port and every engine lane so both see one map
    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (body_hit(a)) begin
            r = body[body_idx(a)];
        end else begin
            case (a)
                ADDR_W'(0): r = reg_g;
                ADDR_W'(1): r = reg_num;
                ADDR_W'(2): r[1] = irq_en;
                ADDR_W'(3): r[2:0] = {st_err, state == S_RUN, st_done};
                ADDR_W'(4): r = step_count;
                default:    r = '0;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        host_wr   = AVL_CS & AVL_WRITE;
        host_rd   = AVL_CS & AVL_READ;
        wr_ctrl   = host_wr && (AVL_ADDR == ADDR_W'(2));
        wr_status = host_wr && (AVL_ADDR == ADDR_W'(3));
        start_req = wr_ctrl && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
        high_wr   = host_wr && (int'(AVL_ADDR) >= 8);
        fs_edge   = fs_s2 & ~fs_s3;
        state_nx  = state;
        start_go  = 1'b0;
        done_evt  = 1'b0;
        err_evt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nx = S_RUN;
                    start_go = 1'b1;
                end
            end
            S_RUN: begin
                err_evt = high_wr || start_req;
                if (ENG_DONE) begin
                    state_nx = S_IDLE;
                    done_evt = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Set events are applied after the W1C so a coincident event wins
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_g      <= '0;
            reg_num    <= '0;
            step_count <= '0;
            irq_en     <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            ENG_START  <= 1'b0;
        end else begin
            ENG_START <= start_go;
            if (host_wr && AVL_ADDR == ADDR_W'(0))
                reg_g <= merge(reg_g, AVL_WRITEDATA, AVL_BYTE_EN);
            if (host_wr && AVL_ADDR == ADDR_W'(1))
                reg_num <= merge(reg_num, AVL_WRITEDATA, AVL_BYTE_EN);
            if (wr_ctrl && AVL_BYTE_EN[0])
                irq_en <= AVL_WRITEDATA[1];
            if (done_evt) begin
                st_done    <= 1'b1;
                step_count <= step_count + 1'b1;
            end else if (wr_status && AVL_BYTE_EN[0] && AVL_WRITEDATA[0]) begin
                st_done <= 1'b0;
            end
            if (err_evt)
                st_err <= 1'b1;
            else if (wr_status && AVL_BYTE_EN[0] && AVL_WRITEDATA[2])
                st_err <= 1'b0;
        end
    end

    // Host owns the body region in IDLE, lanes own it in RUN; later lanes override earlier ones
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < BODY_WORDS; i++) body[i] <= '0;
        end else begin
            if (state == S_IDLE && host_wr && body_hit(AVL_ADDR))
                body[body_idx(AVL_ADDR)] <= merge(body[body_idx(AVL_ADDR)], AVL_WRITEDATA, AVL_BYTE_EN);
            if (ENG_CLEAR_ACC) begin
                for (int i = ACC_LO; i < BODY_WORDS; i++) body[i] <= '0;
            end
            if (state == S_RUN) begin
                for (int l = 0; l < LANES; l++) begin
                    if (ENG_WE[l] && body_hit(ENG_ADDR[l*ADDR_W +: ADDR_W]))
                        body[body_idx(ENG_ADDR[l*ADDR_W +: ADDR_W])] <= ENG_WDATA[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
            ENG_RDATA         <= '0;
            ENG_RVALID        <= '0;
        end else begin
            AVL_READDATAVALID <= host_rd;
            if (host_rd) AVL_READDATA <= read_word(AVL_ADDR);
            ENG_RVALID <= ENG_RE;
            for (int l = 0; l < LANES; l++) begin
                if (ENG_RE[l])
                    ENG_RDATA[l*DATA_W +: DATA_W] <= read_word(ENG_ADDR[l*ADDR_W +: ADDR_W]);
            end
        end
    end

    // Frame edges during a run are deferred so renderers never see a half-updated step
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fs_s1    <= 1'b0;
            fs_s2    <= 1'b0;
            fs_s3    <= 1'b0;
            pending  <= 1'b0;
            DISP_RAD <= '0;
            DISP_PX  <= '0;
            DISP_PY  <= '0;
            DISP_PZ  <= '0;
        end else begin
            fs_s1 <= FRAME_SYNC;
            fs_s2 <= fs_s1;
            fs_s3 <= fs_s2;
            if (state == S_IDLE && (fs_edge || pending)) begin
                pending <= 1'b0;
                for (int i = 0; i < NUM_BODIES; i++) begin
                    DISP_RAD[i*DATA_W +: DATA_W] <= body[1*NUM_BODIES + i];
                    DISP_PX[i*DATA_W +: DATA_W]  <= body[2*NUM_BODIES + i];
                    DISP_PY[i*DATA_W +: DATA_W]  <= body[3*NUM_BODIES + i];
                    DISP_PZ[i*DATA_W +: DATA_W]  <= body[4*NUM_BODIES + i];
                end
            end else if (state == S_RUN && fs_edge) begin
                pending <= 1'b1;
            end
        end
    end

    assign IRQ     = st_done & irq_en;
    assign CFG_G   = reg_g;
    assign CFG_NUM = reg_num;
endmodule
